// File: rtl/ram_minibus_ws.sv
// Word-organised RAM slave on a simple sel/wen/ren minibus, with a configurable
// number of wait states before the array access and one-cycle ack/err strobes.
module ram_minibus_ws #(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_lat;
  logic [3:0]    be_lat;
  logic [31:0]   wdata_lat;
  logic          wen_lat;
  logic          req;
  logic          req_bad;
  logic          accept;
  logic          access;
  logic          unused_off;

  function automatic logic [3:0] byte_en(input logic [1:0] w, input logic [1:0] lo);
    case (w)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic access_err(input logic [1:0] w, input logic [31:0] a,
                                      input logic [31:0] o, input logic both);
    logic out_of_range;
    out_of_range = (a < BASE_ADDR) || ({1'b0, o} >= SPAN);
    return (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00)
           || out_of_range || both;
  endfunction

  assign off        = addr - BASE_ADDR;
  assign idx        = off[AW+1:2];
  assign unused_off = ^{off[31:AW+2], off[1:0]};

  assign req     = sel && (wen || ren);
  assign req_bad = access_err(width, addr, off, wen && ren);
  assign accept  = (state == IDLE) && req && !req_bad;
  // The array is touched only on the final BUSY edge, and never while reset is sampled.
  assign access  = (state == BUSY) && sel && (cnt == 4'd0) && !rst;

  assign ack = (state == RESP);
  assign err = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (req_bad) begin
              state <= ERR;
            end else begin
              state <= BUSY;
              cnt   <= WS_LOAD;
            end
          end
        end
        BUSY: begin
          if (!sel) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
            if (!wen_lat) rdata <= mem[idx_lat];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture: held stable for the whole BUSY phase, so bus changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_lat   <= idx;
      be_lat    <= byte_en(width, addr[1:0]);
      wdata_lat <= wdata;
      wen_lat   <= wen;
    end
  end

  always_ff @(posedge clk) begin
    if (access && wen_lat) begin
      for (int b = 0; b < 4; b++) begin
        if (be_lat[b]) mem[idx_lat][8*b +: 8] <= wdata_lat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_minibus_ws.sv
// Bench for ram_minibus_ws: three instances (wait states 1, 3, 0) checked with a
// directed vector table, hand-written corner sequences and a randomised model run.
module tb_ram_minibus_ws;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        sel   [3];
  logic        wen   [3];
  logic        ren   [3];
  logic [31:0] addr  [3];
  logic [1:0]  width [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [2:0]  ack;
  logic [2:0]  err;

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_minibus_ws #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 3 : 0)),
      .BASE_ADDR  (BASE)
    ) dut (
      .clk  (clk),
      .rst  (rst[g]),
      .sel  (sel[g]),
      .wen  (wen[g]),
      .ren  (ren[g]),
      .addr (addr[g]),
      .width(width[g]),
      .wdata(wdata[g]),
      .rdata(rdata[g]),
      .ack  (ack[g]),
      .err  (err[g])
    );
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (ack[i] === 1'b1 && err[i] === 1'b1) both_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request at #1 after a rising edge; wait (bounded) for ack or err.
  task automatic xact(input int d, input bit w, input bit r, input logic [1:0] wd,
                      input logic [31:0] a, input logic [31:0] wv,
                      output bit got_ack, output bit got_err, output int lat);
    got_ack = 0; got_err = 0; lat = 0;
    sel[d] = 1'b1; wen[d] = w; ren[d] = r; width[d] = wd; addr[d] = a; wdata[d] = wv;
    while (!got_ack && !got_err && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got_ack = (ack[d] === 1'b1);
      got_err = (err[d] === 1'b1);
    end
    sel[d] = 1'b0; wen[d] = 1'b0; ren[d] = 1'b0;
    @(posedge clk); #1;
    chk("strobe_one_cycle", {30'd0, ack[d], err[d]}, 32'd0);
  endtask

  typedef struct {
    bit          w;
    bit          r;
    logic [1:0]  wd;
    logic [31:0] a;
    logic [31:0] wv;
    bit          xerr;
    logic [31:0] xrd;
  } vec_t;

  vec_t tab [16];
  logic [31:0] mref [DEPTH];
  logic [31:0] rd_ref;

  initial begin
    bit ga, ge;
    int lat, acks_seen;
    int q[$];

    tab[0]  = '{1'b1, 1'b0, 2'd2, 32'h1008, 32'hDEADBEEF, 1'b0, 32'h0};
    tab[1]  = '{1'b0, 1'b1, 2'd2, 32'h1008, 32'h0,        1'b0, 32'hDEADBEEF};
    tab[2]  = '{1'b1, 1'b0, 2'd2, 32'h1000, 32'h0,        1'b0, 32'hDEADBEEF};
    tab[3]  = '{1'b1, 1'b0, 2'd0, 32'h1001, 32'h1122AA33, 1'b0, 32'hDEADBEEF};
    tab[4]  = '{1'b1, 1'b0, 2'd0, 32'h1003, 32'h55667788, 1'b0, 32'hDEADBEEF};
    tab[5]  = '{1'b0, 1'b1, 2'd2, 32'h1000, 32'h0,        1'b0, 32'h5500AA00};
    tab[6]  = '{1'b0, 1'b1, 2'd1, 32'h1001, 32'h0,        1'b1, 32'h5500AA00};
    tab[7]  = '{1'b0, 1'b1, 2'd3, 32'h1000, 32'h0,        1'b1, 32'h5500AA00};
    tab[8]  = '{1'b1, 1'b1, 2'd2, 32'h1000, 32'hFFFFFFFF, 1'b1, 32'h5500AA00};
    tab[9]  = '{1'b0, 1'b1, 2'd2, 32'h1040, 32'h0,        1'b1, 32'h5500AA00};
    tab[10] = '{1'b1, 1'b0, 2'd2, 32'h1040, 32'hFFFFFFFF, 1'b1, 32'h5500AA00};
    tab[11] = '{1'b0, 1'b1, 2'd2, 32'h1000, 32'h0,        1'b0, 32'h5500AA00};
    tab[12] = '{1'b1, 1'b0, 2'd1, 32'h1002, 32'h1234FFFF, 1'b0, 32'h5500AA00};
    tab[13] = '{1'b0, 1'b1, 2'd2, 32'h1000, 32'h0,        1'b0, 32'h1234AA00};
    tab[14] = '{1'b1, 1'b0, 2'd2, 32'h0FFC, 32'hFFFFFFFF, 1'b1, 32'h1234AA00};
    tab[15] = '{1'b0, 1'b1, 2'd2, 32'h1008, 32'h0,        1'b0, 32'hDEADBEEF};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; sel[i] = 1'b0; wen[i] = 1'b0; ren[i] = 1'b0;
      addr[i] = 32'h0; width[i] = 2'd0; wdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
      chk($sformatf("reset_ack%0d", i), {31'd0, ack[i]}, 32'd0);
      chk($sformatf("reset_err%0d", i), {31'd0, err[i]}, 32'd0);
    end

    // Directed vectors on the one-wait-state instance
    for (int i = 0; i < 16; i++) begin
      xact(0, tab[i].w, tab[i].r, tab[i].wd, tab[i].a, tab[i].wv, ga, ge, lat);
      chk($sformatf("vec%0d_err", i), {31'd0, ge}, {31'd0, tab[i].xerr});
      chk($sformatf("vec%0d_ack", i), {31'd0, ga}, {31'd0, !tab[i].xerr});
      chk($sformatf("vec%0d_lat", i), lat, tab[i].xerr ? 32'd1 : 32'd3);
      chk($sformatf("vec%0d_rdata", i), rdata[0], tab[i].xrd);
    end

    // Randomised run against the word-array model
    for (int i = 0; i < DEPTH; i++) begin
      mref[i] = $urandom;
      xact(0, 1'b1, 1'b0, 2'd2, BASE + 32'(4 * i), mref[i], ga, ge, lat);
      chk("init_ack", {31'd0, ga}, 32'd1);
    end
    rd_ref = tab[15].xrd;
    for (int n = 0; n < 200; n++) begin
      int op, ws;
      bit w, r, xe;
      logic [1:0] wd;
      logic [31:0] a, wv;
      op = $urandom_range(0, 9);
      w  = (op < 4) || (op == 9);
      r  = (op >= 4);
      ws = $urandom_range(0, 9);
      wd = (ws < 3) ? 2'd0 : (ws < 6) ? 2'd1 : (ws < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 15) == 0) a = BASE - 32'($urandom_range(1, 4));
      else a = BASE + 32'($urandom_range(0, 67));
      wv = $urandom;
      xe = (wd == 2'd3) || (w && r) || (wd == 2'd1 && a % 2 != 0) ||
           (wd == 2'd2 && a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEPTH);
      if (!xe) begin
        int wi, lo;
        wi = int'((a - BASE) / 4);
        lo = int'(a % 4);
        if (w) begin
          for (int b = 0; b < 4; b++)
            if ((wd == 2'd0 && b == lo) || (wd == 2'd1 && b / 2 == lo / 2) || wd == 2'd2)
              mref[wi][8*b +: 8] = wv[8*b +: 8];
        end else begin
          rd_ref = mref[wi];
        end
      end
      xact(0, w, r, wd, a, wv, ga, ge, lat);
      chk($sformatf("rnd%0d_err", n), {31'd0, ge}, {31'd0, xe});
      chk($sformatf("rnd%0d_lat", n), lat, xe ? 32'd1 : 32'd3);
      chk($sformatf("rnd%0d_rdata", n), rdata[0], rd_ref);
    end

    // Three wait states: sel dropped during the second BUSY cycle aborts the write
    xact(1, 1'b1, 1'b0, 2'd2, 32'h1004, 32'h11111111, ga, ge, lat);
    chk("ws3_write_lat", lat, 32'd5);
    sel[1] = 1'b1; wen[1] = 1'b1; ren[1] = 1'b0; width[1] = 2'd2;
    addr[1] = 32'h1004; wdata[1] = 32'h22222222;
    repeat (2) @(posedge clk);
    #1;
    sel[1] = 1'b0; wen[1] = 1'b0;
    acks_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack[1] !== 1'b0 || err[1] !== 1'b0) acks_seen++;
    end
    chk("abort_no_strobe", acks_seen, 32'd0);
    xact(1, 1'b0, 1'b1, 2'd2, 32'h1004, 32'h0, ga, ge, lat);
    chk("abort_word_kept", rdata[1], 32'h11111111);

    // Reset landing on the access edge of a write
    xact(1, 1'b1, 1'b0, 2'd2, 32'h1008, 32'hAAAA5555, ga, ge, lat);
    xact(1, 1'b0, 1'b1, 2'd2, 32'h1008, 32'h0, ga, ge, lat);
    chk("pre_rst_rdata", rdata[1], 32'hAAAA5555);
    sel[1] = 1'b1; wen[1] = 1'b1; ren[1] = 1'b0; width[1] = 2'd2;
    addr[1] = 32'h1008; wdata[1] = 32'hFFFFFFFF;
    repeat (4) @(posedge clk);
    #1;
    rst[1] = 1'b1; sel[1] = 1'b0; wen[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("rst_ack", {31'd0, ack[1]}, 32'd0);
    chk("rst_err", {31'd0, err[1]}, 32'd0);
    chk("rst_rdata", rdata[1], 32'h0);
    acks_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1] !== 1'b0 || err[1] !== 1'b0) acks_seen++;
    end
    chk("rst_no_strobe", acks_seen, 32'd0);
    xact(1, 1'b0, 1'b1, 2'd2, 32'h1008, 32'h0, ga, ge, lat);
    chk("post_rst_ack", {31'd0, ga}, 32'd1);
    chk("post_rst_lat", lat, 32'd5);
    chk("post_rst_word", rdata[1], 32'hAAAA5555);

    // Zero wait states with the request held: one ack every three cycles
    xact(2, 1'b1, 1'b0, 2'd2, 32'h1000, 32'h0BADF00D, ga, ge, lat);
    chk("ws0_write_lat", lat, 32'd2);
    sel[2] = 1'b1; wen[2] = 1'b0; ren[2] = 1'b1; width[2] = 2'd2; addr[2] = 32'h1000;
    acks_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ack[2] === 1'b1) q.push_back(c);
      if (err[2] !== 1'b0) acks_seen++;
    end
    sel[2] = 1'b0; ren[2] = 1'b0;
    chk("ws0_no_err", acks_seen, 32'd0);
    chk("ws0_ack_count", {31'd0, q.size() >= 9}, 32'd1);
    for (int i = 1; i < q.size(); i++)
      chk($sformatf("ws0_period%0d", i), q[i] - q[i-1], 32'd3);
    chk("ws0_rdata", rdata[2], 32'h0BADF00D);
    repeat (2) @(posedge clk);

    chk("ack_err_excl", both_cnt, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
